// File: rtl/memory_arbiter.sv
// Two-master (CPU/DMA) arbiter for a single memory bus: round-robin with DMA
// lock bursts, halt handling with timeout abort and a sticky bus_error flag.
module memory_arbiter #(
  parameter int MAX_LOCK     = 8,
  parameter int HALT_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [23:0] dma_address,
  input  logic [7:0]  dma_wdata,
  input  logic        dma_lock,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [23:0] mem_address,
  output logic [7:0]  mem_data_in,
  output logic        mem_bus_enable,
  output logic        mem_write_enable,
  input  logic [7:0]  mem_data_out,
  input  logic        mem_bus_halt,
  output logic        bus_error
);

  localparam int HCW = (HALT_TIMEOUT > 0) ? $clog2(HALT_TIMEOUT + 1) : 1;
  localparam int LCW = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 1;
  localparam logic [HCW-1:0] HALT_MAX = HCW'(HALT_TIMEOUT);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(MAX_LOCK);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_last_dma, w_last_dma_nxt;
  logic            r_lock_prev, w_lock_prev_nxt;
  logic            r_win_dma, w_win_dma_nxt;
  logic [LCW-1:0]  r_lock_count, w_lock_count_nxt;
  logic [HCW-1:0]  r_halt_count, w_halt_count_nxt;
  logic [23:0]     r_mem_address, w_mem_address_nxt;
  logic [7:0]      r_mem_data_in, w_mem_data_in_nxt;
  logic            r_mem_en, w_mem_en_nxt;
  logic            r_mem_we, w_mem_we_nxt;
  logic            r_cpu_ack, w_cpu_ack_nxt;
  logic            r_dma_ack, w_dma_ack_nxt;
  logic [7:0]      r_cpu_rdata, w_cpu_rdata_nxt;
  logic [7:0]      r_dma_rdata, w_dma_rdata_nxt;
  logic            r_bus_error, w_bus_error_nxt;

  logic w_cpu_elig, w_dma_elig, w_lock_active, w_cpu_hold, w_pick_dma, w_pick_cpu;

  assign w_cpu_elig    = cpu_req & ~r_cpu_ack;
  assign w_dma_elig    = dma_req & ~r_dma_ack;
  assign w_lock_active = r_last_dma & r_lock_prev & (r_lock_count < LOCK_MAX);
  // A live lock reserves the bus through the DMA's own ack cycle, otherwise a
  // held CPU request would always slip in before the DMA can re-request.
  assign w_cpu_hold    = w_lock_active & r_dma_ack;
  assign w_pick_dma    = w_dma_elig & (~w_cpu_elig | ~r_last_dma | w_lock_active);
  assign w_pick_cpu    = w_cpu_elig & ~w_pick_dma & ~w_cpu_hold;

  always_comb begin
    w_state_nxt       = r_state;
    w_last_dma_nxt    = r_last_dma;
    w_lock_prev_nxt   = r_lock_prev;
    w_win_dma_nxt     = r_win_dma;
    w_lock_count_nxt  = r_lock_count;
    w_halt_count_nxt  = r_halt_count;
    w_mem_address_nxt = r_mem_address;
    w_mem_data_in_nxt = r_mem_data_in;
    w_mem_en_nxt      = r_mem_en;
    w_mem_we_nxt      = r_mem_we;
    w_cpu_ack_nxt     = 1'b0;
    w_dma_ack_nxt     = 1'b0;
    w_cpu_rdata_nxt   = r_cpu_rdata;
    w_dma_rdata_nxt   = r_dma_rdata;
    w_bus_error_nxt   = r_bus_error;
    case (r_state)
      IDLE: begin
        w_mem_en_nxt = 1'b0;
        w_mem_we_nxt = 1'b0;
        if (w_pick_dma) begin
          w_state_nxt       = ACCESS;
          w_win_dma_nxt     = 1'b1;
          w_last_dma_nxt    = 1'b1;
          w_lock_prev_nxt   = dma_lock;
          w_mem_address_nxt = dma_address;
          w_mem_data_in_nxt = dma_wdata;
          w_mem_we_nxt      = dma_we;
          w_mem_en_nxt      = 1'b1;
          w_halt_count_nxt  = '0;
          if (!dma_lock)
            w_lock_count_nxt = '0;
          else if (cpu_req && (r_lock_count < LOCK_MAX))
            w_lock_count_nxt = r_lock_count + LCW'(1);
        end else if (w_pick_cpu) begin
          w_state_nxt       = ACCESS;
          w_win_dma_nxt     = 1'b0;
          w_last_dma_nxt    = 1'b0;
          w_lock_prev_nxt   = 1'b0;
          w_lock_count_nxt  = '0;
          w_mem_address_nxt = cpu_address;
          w_mem_data_in_nxt = cpu_wdata;
          w_mem_we_nxt      = cpu_we;
          w_mem_en_nxt      = 1'b1;
          w_halt_count_nxt  = '0;
        end
      end
      ACCESS: begin
        if (!mem_bus_halt || (r_halt_count == HALT_MAX)) begin
          w_state_nxt   = IDLE;
          w_mem_en_nxt  = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_cpu_ack_nxt = ~r_win_dma;
          w_dma_ack_nxt = r_win_dma;
          if (mem_bus_halt) begin
            w_bus_error_nxt = 1'b1;
            if (r_win_dma) w_dma_rdata_nxt = '1;
            else           w_cpu_rdata_nxt = '1;
          end else if (!r_mem_we) begin
            if (r_win_dma) w_dma_rdata_nxt = mem_data_out;
            else           w_cpu_rdata_nxt = mem_data_out;
          end
        end else begin
          w_halt_count_nxt = r_halt_count + HCW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_last_dma    <= 1'b1;
      r_lock_prev   <= 1'b0;
      r_win_dma     <= 1'b0;
      r_lock_count  <= '0;
      r_halt_count  <= '0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_dma_ack     <= 1'b0;
      r_cpu_rdata   <= '0;
      r_dma_rdata   <= '0;
      r_bus_error   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_dma    <= w_last_dma_nxt;
      r_lock_prev   <= w_lock_prev_nxt;
      r_win_dma     <= w_win_dma_nxt;
      r_lock_count  <= w_lock_count_nxt;
      r_halt_count  <= w_halt_count_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_data_in <= w_mem_data_in_nxt;
      r_mem_en      <= w_mem_en_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_cpu_ack     <= w_cpu_ack_nxt;
      r_dma_ack     <= w_dma_ack_nxt;
      r_cpu_rdata   <= w_cpu_rdata_nxt;
      r_dma_rdata   <= w_dma_rdata_nxt;
      r_bus_error   <= w_bus_error_nxt;
    end
  end

  assign cpu_ack          = r_cpu_ack;
  assign dma_ack          = r_dma_ack;
  assign cpu_rdata        = r_cpu_rdata;
  assign dma_rdata        = r_dma_rdata;
  assign mem_address      = r_mem_address;
  assign mem_data_in      = r_mem_data_in;
  assign mem_bus_enable   = r_mem_en;
  assign mem_write_enable = r_mem_we;
  assign bus_error        = r_bus_error;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: expected acks are queued as stimulus is
// driven and popped by a monitor when the arbiter acknowledges.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [23:0] cpu_address;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_lock, dma_ack;
  logic [23:0] dma_address;
  logic [7:0]  dma_wdata, dma_rdata;
  logic [23:0] mem_address;
  logic [7:0]  mem_data_in, mem_data_out;
  logic        mem_bus_enable, mem_write_enable, mem_bus_halt, bus_error;

  typedef struct {
    bit         is_dma;
    logic [7:0] rdata;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  logic [7:0] m_cpu_rd, m_dma_rd;
  int         n_assert = 0;
  int         n_fail   = 0;

  memory_arbiter #(.MAX_LOCK(8), .HALT_TIMEOUT(1023)) dut (
    .clk(clk), .reset(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address),
    .dma_wdata(dma_wdata), .dma_lock(dma_lock), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_bus_enable(mem_bus_enable), .mem_write_enable(mem_write_enable),
    .mem_data_out(mem_data_out), .mem_bus_halt(mem_bus_halt), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input bit is_dma, input bit is_wr, input logic [7:0] d);
    logic [7:0] r;
    if (is_dma) begin
      r = is_wr ? m_dma_rd : d;
      m_dma_rd = r;
    end else begin
      r = is_wr ? m_cpu_rd : d;
      m_cpu_rd = r;
    end
    q.push_back('{is_dma, r});
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack === 1'b1 || dma_ack === 1'b1) seen++;
    end
    chk(tag, 32'(seen), 32'(n));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(mem_address), 32'h0);
    chk({tag, "_din"}, 32'(mem_data_in), 32'h0);
    chk({tag, "_en"}, 32'(mem_bus_enable), 32'h0);
    chk({tag, "_we"}, 32'(mem_write_enable), 32'h0);
    chk({tag, "_cack"}, 32'(cpu_ack), 32'h0);
    chk({tag, "_dack"}, 32'(dma_ack), 32'h0);
    chk({tag, "_crd"}, 32'(cpu_rdata), 32'h0);
    chk({tag, "_drd"}, 32'(dma_rdata), 32'h0);
    chk({tag, "_berr"}, 32'(bus_error), 32'h0);
  endtask

  // Scoreboard monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (cpu_ack === 1'b1 || dma_ack === 1'b1)) begin
      chk("ack_exclusive", 32'(cpu_ack & dma_ack), 32'h0);
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'({cpu_ack, dma_ack}), 32'h0);
      end else begin
        e = q.pop_front();
        chk("ack_master", 32'(dma_ack), 32'(e.is_dma));
        chk("ack_rdata", 32'(e.is_dma ? dma_rdata : cpu_rdata), 32'(e.rdata));
      end
    end
  end

  initial begin
    bit early;
    rst_n = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_address = '0; dma_wdata = '0;
    mem_data_out = '0; mem_bus_halt = 1'b0;
    m_cpu_rd = '0; m_dma_rd = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single CPU read: latency and data
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 24'h000010; mem_data_out = 8'h5A;
    push(1'b0, 1'b0, 8'h5A);
    @(negedge clk);
    chk("rd_en", 32'(mem_bus_enable), 32'h1);
    chk("rd_addr", 32'(mem_address), 32'h10);
    chk("rd_we", 32'(mem_write_enable), 32'h0);
    chk("rd_noack", 32'(cpu_ack), 32'h0);
    @(negedge clk);
    chk("rd_ack", 32'(cpu_ack), 32'h1);
    chk("rd_data", 32'(cpu_rdata), 32'h5A);
    chk("rd_en_drop", 32'(mem_bus_enable), 32'h0);
    cpu_req = 1'b0;

    // Round-robin with both requesting; CPU was granted last
    @(negedge clk);
    cpu_req = 1'b1; dma_req = 1'b1; dma_lock = 1'b0; dma_we = 1'b0;
    cpu_address = 24'h000200; dma_address = 24'h000300; mem_data_out = 8'h33;
    push(1'b1, 1'b0, 8'h33); push(1'b0, 1'b0, 8'h33);
    push(1'b1, 1'b0, 8'h33); push(1'b0, 1'b0, 8'h33);
    wait_acks(4, 40, "rr_acks");
    cpu_req = 1'b0; dma_req = 1'b0;

    // Locked DMA burst against a held CPU request
    @(negedge clk);
    dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b0; mem_data_out = 8'h6C;
    push(1'b1, 1'b0, 8'h6C);
    @(negedge clk);
    cpu_req = 1'b1;
    for (int unsigned i = 0; i < 8; i++) push(1'b1, 1'b0, 8'h6C);
    push(1'b0, 1'b0, 8'h6C);
    wait_acks(10, 120, "lock_acks");
    chk("lock_count_clr", 32'(dut.r_lock_count), 32'h0);
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;

    // DMA write held by 5 halt cycles
    @(negedge clk);
    dma_req = 1'b1; dma_we = 1'b1; dma_address = 24'h01C000; dma_wdata = 8'hA7;
    mem_bus_halt = 1'b1;
    push(1'b1, 1'b1, 8'h00);
    @(negedge clk);
    for (int unsigned i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk("halt_addr", 32'(mem_address), 32'h01C000);
      chk("halt_din", 32'(mem_data_in), 32'hA7);
      chk("halt_en", 32'(mem_bus_enable), 32'h1);
      chk("halt_we", 32'(mem_write_enable), 32'h1);
      chk("halt_noack", 32'(dma_ack), 32'h0);
    end
    mem_bus_halt = 1'b0;
    @(negedge clk);
    chk("halt_ack", 32'(dma_ack), 32'h1);
    chk("halt_berr", 32'(bus_error), 32'h0);
    dma_req = 1'b0;

    // Stuck halt: timeout abort
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 24'h000123;
    mem_data_out = 8'h11; mem_bus_halt = 1'b1;
    push(1'b0, 1'b0, 8'hFF);
    @(negedge clk);
    chk("to_en", 32'(mem_bus_enable), 32'h1);
    early = 1'b0;
    repeat (1023) begin
      @(negedge clk);
      if (cpu_ack !== 1'b0) early = 1'b1;
    end
    chk("to_early_ack", 32'(early), 32'h0);
    chk("to_halt_count", 32'(dut.r_halt_count), 32'd1023);
    chk("to_berr_pre", 32'(bus_error), 32'h0);
    @(negedge clk);
    chk("to_ack", 32'(cpu_ack), 32'h1);
    chk("to_rdata", 32'(cpu_rdata), 32'hFF);
    chk("to_berr", 32'(bus_error), 32'h1);
    chk("to_en_drop", 32'(mem_bus_enable), 32'h0);
    cpu_req = 1'b0; mem_bus_halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("berr_sticky", 32'(bus_error), 32'h1);

    // Reset in the middle of an access, then a tie after release
    dma_req = 1'b1; dma_we = 1'b1; dma_address = 24'h000ABC; dma_wdata = 8'h5C;
    mem_bus_halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_en", 32'(mem_bus_enable), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    m_cpu_rd = '0; m_dma_rd = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 24'h00C0DE;
    dma_we = 1'b0; dma_lock = 1'b0; mem_bus_halt = 1'b0; mem_data_out = 8'h9E;
    @(negedge clk);
    chk("rst_hold_en", 32'(mem_bus_enable), 32'h0);
    rst_n = 1'b1;
    push(1'b0, 1'b0, 8'h9E); push(1'b1, 1'b0, 8'h9E);
    @(negedge clk);
    chk("post_rst_en", 32'(mem_bus_enable), 32'h1);
    chk("post_rst_addr", 32'(mem_address), 32'h00C0DE);
    wait_acks(2, 20, "post_rst_acks");
    cpu_req = 1'b0; dma_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter MAX_LOCK, default 8, meaning the maximum number of consecutive DMA accesses under dma_lock while a CPU request is pending.
REQ-002 SHALL have parameter HALT_TIMEOUT, default 1023, meaning the maximum number of cycles an access waits on mem_bus_halt before being aborted.
REQ-003 SHALL have ports, clock and reset first:
  clk  input  1  single clock; all state changes on its rising edge.
  reset  input  1  asynchronous, active-low reset.
  cpu_req  input  1  CPU access request, held until cpu_ack.
  cpu_we  input  1  CPU write (1) / read (0).
  cpu_address  input  24  CPU byte address.
  cpu_wdata  input  8  CPU write data.
  cpu_ack  output  1  one-cycle completion pulse to CPU.
  cpu_rdata  output  8  CPU read data, valid while cpu_ack=1.
  dma_req  input  1  DMA access request, held until dma_ack.
  dma_we  input  1  DMA write (1) / read (0).
  dma_address  input  24  DMA byte address.
  dma_wdata  input  8  DMA write data.
  dma_lock  input  1  DMA asks to keep the grant for its next access.
  dma_ack  output  1  one-cycle completion pulse to DMA.
  dma_rdata  output  8  DMA read data, valid while dma_ack=1.
  mem_address  output  24  address to memory_bus.
  mem_data_in  output  8  write data to memory_bus.
  mem_bus_enable  output  1  access strobe to memory_bus.
  mem_write_enable  output  1  write strobe to memory_bus.
  mem_data_out  input  8  read data from memory_bus.
  mem_bus_halt  input  1  memory not ready; hold the access.
  bus_error  output  1  sticky flag set by a halt timeout.

Function
REQ-004 SHALL implement states IDLE, ACCESS; all mem_* outputs, acks, rdata and bus_error SHALL be registered.
REQ-005 In IDLE, a request SHALL be eligible if its req=1 and its own ack is not high in that cycle; no eligible request -> stay IDLE, mem_bus_enable=0, mem_write_enable=0.
REQ-006 If one request is eligible, it SHALL be granted; if both are eligible, the master not granted last SHALL win (round-robin; last_grant resets to DMA, so the CPU wins the first tie).
REQ-007 Lock override: if the last grant was DMA with dma_lock=1 at its grant, and lock_count < MAX_LOCK, DMA SHALL win a tie.
REQ-008 lock_count SHALL increment on each locked DMA grant made while cpu_req=1, and SHALL clear on any CPU grant or any DMA grant with dma_lock=0.
REQ-009 On grant, the next cycle SHALL enter ACCESS with mem_address, mem_data_in and mem_write_enable loaded from the winner, mem_bus_enable=1, and halt_count=0.
REQ-010 In ACCESS with mem_bus_halt=0, the arbiter SHALL, on the next cycle:
  - capture mem_data_out into the winner's rdata (reads only; rdata is unchanged on writes);
  - pulse the winner's ack for one cycle;
  - drop mem_bus_enable and mem_write_enable;
  - return to IDLE.
REQ-011 In ACCESS with mem_bus_halt=1, the arbiter SHALL hold all mem_* outputs stable and increment halt_count.
REQ-012 If halt_count reaches HALT_TIMEOUT while mem_bus_halt=1, the arbiter SHALL on the next cycle:
  - abort the access and return to IDLE;
  - pulse the winner's ack with rdata=8'hFF;
  - set bus_error=1; only reset clears it.
REQ-013 Minimum latency: req sampled in IDLE at cycle N -> mem_bus_enable=1 at N+1 -> ack=1 at N+2 when no halt; one access every 2 cycles maximum.
REQ-014 Requester inputs SHALL be sampled only at grant; changes during ACCESS SHALL have no effect.
REQ-015 cpu_ack and dma_ack SHALL never be high in the same cycle; at most one master SHALL be in ACCESS at a time.
REQ-016 Counters SHALL saturate and never wrap: halt_count is clog2(HALT_TIMEOUT+1) bits; lock_count is clog2(MAX_LOCK+1) bits.

Reset
REQ-017 reset=0 SHALL immediately, asynchronously, force:
  - state=IDLE, last_grant=DMA, lock_count=0, halt_count=0;
  - mem_address=0, mem_data_in=0, mem_bus_enable=0, mem_write_enable=0;
  - cpu_ack=0, dma_ack=0, cpu_rdata=0, dma_rdata=0, bus_error=0.
REQ-018 Reset during ACCESS SHALL abandon the access with no ack; the first grant SHALL occur no earlier than the first clk edge after reset returns to 1.

Verification
REQ-019 CPU read 0x000010, mem_data_out=8'h5A, no halt -> mem_bus_enable=1 at N+1, mem_address=0x000010, cpu_ack=1 with cpu_rdata=8'h5A at N+2.
REQ-020 cpu_req and dma_req rise together repeatedly, dma_lock=0 -> grants alternate CPU, DMA, CPU, DMA; no cycle with both acks high.
REQ-021 DMA locked burst with cpu_req held=1, MAX_LOCK=8 -> after the first DMA grant, exactly 8 further DMA grants, then a CPU grant; lock_count=0 afterwards.
REQ-022 DMA write to 0x01C000, mem_bus_halt=1 for 5 cycles -> mem_* outputs stable throughout, mem_write_enable=1, dma_ack 1 cycle after halt drops, bus_error=0.
REQ-023 mem_bus_halt stuck at 1, HALT_TIMEOUT=1023 -> ack with rdata=8'hFF on the cycle after halt_count reaches 1023, bus_error=1 until reset=0.
REQ-024 reset=0 asserted mid-ACCESS -> all outputs 0 immediately, no ack; a CPU request after reset release is granted first on a tie.
